anthem_rx_checker: RTL

- Receive-side counterpart to the anthem character transmitter.
- Samples an ASCII byte stream presented on the input pins, one byte per external strobe pulse.
- Compares each byte in order against the on-chip reference string "SOY DE ZACAPA" (13 chars).
- Reports progress, a sticky match/fail verdict, the last accepted byte and a received-byte count. Sits between the TT pin wrapper and the 7-segment/status outputs.

---
 rtl/anthem_rx_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/anthem_rx_checker.sv
// anthem_rx_checker: receive-side comparator of a strobed ASCII stream against "SOY DE ZACAPA".
// Optional build macro CASE_FOLD_EN: fold lowercase a..z to uppercase before comparison.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | no byte compared since reset/clear
//   S_RUN   | prefix of the reference matched, more expected
//   S_MATCH | all 13 characters received correctly (sticky)
//   S_FAIL  | a mismatch occurred at position idx (sticky)
module anthem_rx_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic             i_clear,
  input  logic             i_strobe,
  input  logic [7:0]       i_data_in,
  output logic [3:0]       o_idx,
  output logic             o_busy,
  output logic             o_match,
  output logic             o_fail,
  output logic [7:0]       o_last_byte,
  output logic [CNT_W-1:0] o_byte_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MATCH, S_FAIL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_idx, w_idx_nxt;
  logic [7:0]             r_last, w_last_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_sync_out;
  logic                   w_accept;
  logic [7:0]             w_cmp;
  logic                   w_hit;

  function automatic logic [7:0] rom_char(input logic [3:0] a);
    case (a)
      4'd0:    rom_char = 8'h53;
      4'd1:    rom_char = 8'h4F;
      4'd2:    rom_char = 8'h59;
      4'd3:    rom_char = 8'h20;
      4'd4:    rom_char = 8'h44;
      4'd5:    rom_char = 8'h45;
      4'd6:    rom_char = 8'h20;
      4'd7:    rom_char = 8'h5A;
      4'd8:    rom_char = 8'h41;
      4'd9:    rom_char = 8'h43;
      4'd10:   rom_char = 8'h41;
      4'd11:   rom_char = 8'h50;
      4'd12:   rom_char = 8'h41;
      default: rom_char = 8'h00;
    endcase
  endfunction

  // The synchronizer resets low, so a strobe already high at reset release would look like
  // a rising edge. r_armed only opens once the filled pipeline has shown the strobe low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_warm  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_warm  <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= w_sync_out;
      r_armed <= r_armed | ((&r_warm) & ~w_sync_out);
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_accept   = w_sync_out & ~r_prev & i_ena & r_armed;

`ifdef CASE_FOLD_EN
  assign w_cmp = ((i_data_in >= 8'h61) && (i_data_in <= 8'h7A)) ? (i_data_in - 8'h20) : i_data_in;
`else
  assign w_cmp = i_data_in;
`endif

  assign w_hit = (w_cmp == rom_char(r_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_last  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 4'd0;
      w_last_nxt  = 8'h00;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_last_nxt = i_data_in;
      if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (!w_hit) begin
            w_state_nxt = S_FAIL;
          end else if (r_idx == 4'd12) begin
            w_idx_nxt   = 4'd13;
            w_state_nxt = S_MATCH;
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_idx       = r_idx;
  assign o_busy      = (r_state == S_RUN);
  assign o_match     = (r_state == S_MATCH);
  assign o_fail      = (r_state == S_FAIL);
  assign o_last_byte = r_last;
  assign o_byte_cnt  = r_cnt;

endmodule
